pwm8_compare: RTL and testbench
===============================

Name: pwm8_compare

Overview:
- Downstream consumer of the free-running 8-bit counter with carry-out (Counter8_COUT).
- Takes the counter value O and the wrap pulse COUT and produces a period-aligned PWM waveform with double-buffered duty, a period counter and a sticky wrap interrupt.
- Duty updates take effect only at period boundaries, so the PWM output never glitches.

Parameters:
WIDTH, 8, width of counter input and duty registers
PWIDTH, 8, width of the completed-period counter

Ports:
CLK  input  1  clock, rising edge
ASYNCRESET  input  1  asynchronous, active-high reset
CNT  input  WIDTH  counter value (counter O)
WRAP  input  1  counter carry-out (COUT); high during the cycle CNT==all-ones
EN  input  1  enable PWM generation
DUTY  input  WIDTH  new duty value
DUTY_WE  input  1  write strobe for DUTY
IRQ_ACK  input  1  clears IRQ
PWM  output  1  registered PWM output
DUTY_ACTIVE  output  WIDTH  duty value currently in use
PERIODS  output  PWIDTH  wrap count since enable
IRQ  output  1  sticky wrap interrupt

Behaviour:
- Reset (async, immediate):
  - PWM=0, DUTY_ACTIVE=0, PERIODS=0, IRQ=0.
  - pending=0, pending_valid=0, state=IDLE.
- Duty buffering:
  - DUTY_WE=1: pending<=DUTY, pending_valid<=1. A later write overwrites pending.
  - Edge with WRAP=1 and pending_valid=1 (pre-edge): DUTY_ACTIVE<=pending. pending_valid<=0 unless DUTY_WE=1 that same cycle.
  - The transfer happens in any state.
  - DUTY_WE coincident with WRAP: the transfer uses the pre-edge pending value; the new DUTY stays pending for the next wrap.
- FSM (state register, 2 bits):
  - IDLE: EN=1 -> ARMED.
  - ARMED: EN=0 -> IDLE; WRAP=1 -> RUN.
  - RUN: EN=0 -> IDLE.
  - EN=0 has priority over WRAP.
- PWM (1-cycle latency): PWM(t+1) = (state(t)==RUN) & EN(t) & (CNT(t) < DUTY_ACTIVE(t)), unsigned compare.
  - Duty D gives exactly D high cycles per 2^WIDTH cycles. D=0: constant low. D=0xFF: 255 of 256 cycles high.
  - No partial first period: PWM stays low in ARMED.
  - EN dropping in RUN forces PWM=0 on the next edge.
- PERIODS:
  - Increments by 1 on edges with WRAP=1 and state in {ARMED, RUN} with EN=1.
  - Wraps modulo 2^PWIDTH (0xFF -> 0x00).
  - Cleared to 0 on the IDLE->ARMED transition.
- IRQ:
  - Set condition equals the PERIODS increment condition.
  - IRQ_ACK=1 clears IRQ.
  - Set and ACK in the same cycle: set wins, IRQ stays 1.
  - IRQ is unaffected by state changes other than reset.
- Reset asserted mid-period returns all state to reset values. After release, the FSM needs EN plus a WRAP before PWM toggles again.

Test Plan:
1. Reset in RUN with PWM=1, PERIODS=5, IRQ=1: assert ASYNCRESET between edges -> all outputs 0 before the next CLK edge. After release, PWM stays 0 until EN=1 and a WRAP.
2. Write DUTY=0x40 in IDLE, set EN=1, drive CNT/WRAP from a free-running Counter8_COUT starting at 0x37:
   - PWM=0 while ARMED.
   - At the first WRAP edge: DUTY_ACTIVE=0x40, PERIODS=1, IRQ=1.
   - PWM then high 64 cycles and low 192 cycles, repeating.
3. Mid-period write: in RUN with duty 0x40, write 0x80 at CNT=0x10 -> current period still 64 high cycles; next period 128 high; DUTY_ACTIVE changes exactly at the WRAP edge.
4. Coincident write: pending=0x20 valid, DUTY_WE with DUTY=0x90 on the WRAP cycle -> DUTY_ACTIVE=0x20 and pending_valid=1; at the next WRAP, DUTY_ACTIVE=0x90.
5. Interrupt handling:
   - IRQ_ACK on the same cycle as WRAP -> IRQ remains 1.
   - IRQ_ACK on a non-WRAP cycle -> IRQ=0 next cycle.
   - EN drop in RUN -> PWM=0 next cycle, state IDLE, IRQ unchanged.
6. Extremes:
   - Duty 0x00 -> PWM never high over 2 periods.
   - Duty 0xFF -> exactly one low cycle per period (the CNT=0xFF compare).
   - Run 256 periods -> PERIODS wraps 0xFF->0x00 with IRQ set.

Source files
------------

// File: rtl/pwm8_compare_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm8_compare_if
// Description : Bus bundle between the counter/host side and the PWM compare
//               block: counter value, wrap pulse, duty programming, interrupt
//               acknowledge, plus the PWM status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm8_compare_if #(
  parameter int WIDTH  = 8,
  parameter int PWIDTH = 8
);
  logic [WIDTH-1:0]  CNT;
  logic              WRAP;
  logic              EN;
  logic [WIDTH-1:0]  DUTY;
  logic              DUTY_WE;
  logic              IRQ_ACK;
  logic              PWM;
  logic [WIDTH-1:0]  DUTY_ACTIVE;
  logic [PWIDTH-1:0] PERIODS;
  logic              IRQ;

  // Host / counter side: drives the counter and control inputs.
  modport master (
    output CNT, WRAP, EN, DUTY, DUTY_WE, IRQ_ACK,
    input  PWM, DUTY_ACTIVE, PERIODS, IRQ
  );

  // PWM compare block side.
  modport slave (
    input  CNT, WRAP, EN, DUTY, DUTY_WE, IRQ_ACK,
    output PWM, DUTY_ACTIVE, PERIODS, IRQ
  );
endinterface
`default_nettype wire

// File: rtl/pwm8_compare.sv
`default_nettype none
// ============================================================================
// Module      : pwm8_compare
// Description : Period-aligned PWM generator fed by a free-running counter
//               and its wrap pulse. Duty is double-buffered and only swapped
//               on a wrap edge, so the output never glitches mid-period.
//               Also counts completed periods and raises a sticky interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm8_compare #(
  parameter int WIDTH  = 8,
  parameter int PWIDTH = 8
) (
  input  logic          CLK,
  input  logic          ASYNCRESET,
  pwm8_compare_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    pending_q, pending_d;
  logic                pending_valid_q, pending_valid_d;
  logic [WIDTH-1:0]    duty_active_q, duty_active_d;
  logic                pwm_q, pwm_d;
  logic [PWIDTH-1:0]   periods_q, periods_d;
  logic                irq_q, irq_d;
  logic                period_evt;

  // Next-state, duty buffering, PWM compare, period count and interrupt.
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    duty_active_d   = duty_active_q;
    periods_d       = periods_q;
    irq_d           = irq_q;

    // A completed period only counts while the generator is enabled and armed/running.
    period_evt = bus.WRAP && bus.EN && (state_q == ST_ARMED || state_q == ST_RUN);

    // EN low always wins over a wrap.
    case (state_q)
      ST_IDLE: begin
        if (bus.EN) begin
          state_d   = ST_ARMED;
          periods_d = '0;
        end
      end
      ST_ARMED: begin
        if (!bus.EN)       state_d = ST_IDLE;
        else if (bus.WRAP) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.EN) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Wrap consumes the pre-edge pending value; a write in the same cycle
    // lands in the buffer afterwards and stays valid for the next wrap.
    if (bus.WRAP && pending_valid_q) begin
      duty_active_d   = pending_q;
      pending_valid_d = 1'b0;
    end
    if (bus.DUTY_WE) begin
      pending_d       = bus.DUTY;
      pending_valid_d = 1'b1;
    end

    if (period_evt) begin
      periods_d = periods_q + PWIDTH'(1);
    end

    // Set has priority over acknowledge.
    if (period_evt)       irq_d = 1'b1;
    else if (bus.IRQ_ACK) irq_d = 1'b0;

    pwm_d = (state_q == ST_RUN) && bus.EN && (bus.CNT < duty_active_q);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q         <= ST_IDLE;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      duty_active_q   <= '0;
      pwm_q           <= 1'b0;
      periods_q       <= '0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      duty_active_q   <= duty_active_d;
      pwm_q           <= pwm_d;
      periods_q       <= periods_d;
      irq_q           <= irq_d;
    end
  end

  assign bus.PWM         = pwm_q;
  assign bus.DUTY_ACTIVE = duty_active_q;
  assign bus.PERIODS     = periods_q;
  assign bus.IRQ         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm8_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm8_compare
// Description : Self-checking bench for pwm8_compare: a vector table for
//               single-cycle behaviour, then a modelled free-running counter
//               for whole-period duty, buffering, interrupt and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm8_compare;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm8_compare_if #(.WIDTH(8), .PWIDTH(8)) bus ();

  pwm8_compare #(.WIDTH(8), .PWIDTH(8)) dut (
    .CLK        (clk),
    .ASYNCRESET (rst),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] cnt_m;

  typedef struct {
    logic       en;
    logic       we;
    logic [7:0] duty;
    logic       ack;
    logic [7:0] cnt;
    logic       wrap;
    logic       e_pwm;
    logic [7:0] e_da;
    logic [7:0] e_per;
    logic       e_irq;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic p, input logic [7:0] da,
                            input logic [7:0] per, input logic irq);
    check({name, ".pwm"}, 32'(bus.PWM), 32'(p));
    check({name, ".duty_active"}, 32'(bus.DUTY_ACTIVE), 32'(da));
    check({name, ".periods"}, 32'(bus.PERIODS), 32'(per));
    check({name, ".irq"}, 32'(bus.IRQ), 32'(irq));
  endtask

  // One cycle of the modelled free-running counter.
  task automatic tick();
    bus.CNT  = cnt_m;
    bus.WRAP = (cnt_m == 8'hFF);
    @(posedge clk);
    #1;
    cnt_m       = cnt_m + 8'd1;
    bus.DUTY_WE = 1'b0;
    bus.IRQ_ACK = 1'b0;
  endtask

  // Runs through the next wrap edge, counting PWM high samples.
  task automatic run_to_wrap(output int highs, output bit ok);
    highs = 0;
    ok    = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = (cnt_m == 8'hFF);
      tick();
      if (bus.PWM) highs++;
    end
  endtask

  // One full period starting at CNT=0, ending with the wrap edge.
  task automatic run_period(input logic [7:0] wa, input logic [7:0] va, input logic ea,
                            input logic [7:0] wb, input logic [7:0] vb, input logic eb,
                            output int highs, output logic [7:0] da_last);
    highs   = 0;
    da_last = '0;
    for (int i = 0; i < 256; i++) begin
      if (ea && cnt_m == wa) begin bus.DUTY = va; bus.DUTY_WE = 1'b1; end
      if (eb && cnt_m == wb) begin bus.DUTY = vb; bus.DUTY_WE = 1'b1; end
      if (i == 255) da_last = bus.DUTY_ACTIVE;
      tick();
      if (bus.PWM) highs++;
    end
  endtask

  initial begin
    int h;
    bit ok;
    logic [7:0] dl;

    //           en    we    duty   ack   cnt    wrap   pwm   da     per    irq
    vecs[0]  = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h40, 8'h01, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 8'h01, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h3F, 1'b0, 1'b1, 8'h40, 8'h01, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0, 1'b0, 8'h40, 8'h01, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b1, 8'h40, 8'h01, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h10, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h40, 8'h02, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b1, 8'h40, 8'h02, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h10, 8'h03, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h10, 8'h03, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0, 8'h10, 8'h03, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 8'h03, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h10, 8'h03, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1};

    rst         = 1'b1;
    bus.CNT     = '0;
    bus.WRAP    = 1'b0;
    bus.EN      = 1'b0;
    bus.DUTY    = '0;
    bus.DUTY_WE = 1'b0;
    bus.IRQ_ACK = 1'b0;
    cnt_m       = '0;
    #2;
    check_outs("reset", 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-cycle vector table.
    for (int i = 0; i < 17; i++) begin
      bus.EN      = vecs[i].en;
      bus.DUTY_WE = vecs[i].we;
      bus.DUTY    = vecs[i].duty;
      bus.IRQ_ACK = vecs[i].ack;
      bus.CNT     = vecs[i].cnt;
      bus.WRAP    = vecs[i].wrap;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_pwm, vecs[i].e_da, vecs[i].e_per, vecs[i].e_irq);
      bus.DUTY_WE = 1'b0;
      bus.IRQ_ACK = 1'b0;
    end

    // Fresh start, duty 0x40 written in IDLE, counter from 0x37.
    bus.EN = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_m = 8'h37;
    bus.DUTY = 8'h40;
    bus.DUTY_WE = 1'b1;
    tick();
    bus.EN = 1'b1;
    run_to_wrap(h, ok);
    check("armed_wrap_seen", 32'(ok), 32'd1);
    check("armed_pwm_low", 32'(h), 32'd0);
    check_outs("first_wrap", 1'b0, 8'h40, 8'h01, 1'b1);

    run_period(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, h, dl);
    check("p1_highs", 32'(h), 32'd64);
    check("p1_da", 32'(bus.DUTY_ACTIVE), 32'h40);

    run_period(8'h10, 8'h80, 1'b1, 8'h00, 8'h00, 1'b0, h, dl);
    check("p2_highs", 32'(h), 32'd64);
    check("p2_da_before_wrap", 32'(dl), 32'h40);
    check("p2_da_after_wrap", 32'(bus.DUTY_ACTIVE), 32'h80);

    run_period(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, h, dl);
    check("p3_highs", 32'(h), 32'd128);

    run_period(8'h30, 8'h20, 1'b1, 8'hFF, 8'h90, 1'b1, h, dl);
    check("p4_highs", 32'(h), 32'd128);
    check("coincident_da", 32'(bus.DUTY_ACTIVE), 32'h20);

    run_period(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, h, dl);
    check("p5_highs", 32'(h), 32'd32);
    check("coincident_next_da", 32'(bus.DUTY_ACTIVE), 32'h90);
    check("p5_periods", 32'(bus.PERIODS), 32'd6);

    run_period(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, h, dl);
    check("p6_highs", 32'(h), 32'd144);

    // Interrupt acknowledge off and on the wrap cycle.
    bus.IRQ_ACK = 1'b1;
    tick();
    check("ack_clears_irq", 32'(bus.IRQ), 32'd0);
    for (int i = 0; i < 300 && cnt_m != 8'hFF; i++) tick();
    bus.IRQ_ACK = 1'b1;
    tick();
    check("ack_on_wrap_irq", 32'(bus.IRQ), 32'd1);
    check("ack_on_wrap_periods", 32'(bus.PERIODS), 32'd8);

    // Duty extremes.
    run_period(8'h05, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, h, dl);
    check("p9_highs", 32'(h), 32'd144);
    run_period(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, h, dl);
    check("duty00_a", 32'(h), 32'd0);
    run_period(8'h05, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0, h, dl);
    check("duty00_b", 32'(h), 32'd0);
    check("duty00_b_last_sample", 32'(bus.PWM), 32'd0);
    run_period(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, h, dl);
    check("dutyFF_highs", 32'(h), 32'd255);
    check("dutyFF_low_at_ff", 32'(bus.PWM), 32'd0);
    check("periods_12", 32'(bus.PERIODS), 32'd12);

    // EN drop while running.
    tick();
    check("run_pwm_high", 32'(bus.PWM), 32'd1);
    tick();
    bus.EN = 1'b0;
    tick();
    check("en_drop_pwm", 32'(bus.PWM), 32'd0);
    check("en_drop_irq", 32'(bus.IRQ), 32'd1);
    run_to_wrap(h, ok);
    check("idle_no_pwm", 32'(h), 32'd0);
    check("idle_periods_hold", 32'(bus.PERIODS), 32'd12);

    // Re-enable clears PERIODS, then run to PERIODS wrap-around.
    bus.EN = 1'b1;
    tick();
    check("arm_clears_periods", 32'(bus.PERIODS), 32'd0);
    run_to_wrap(h, ok);
    check("rearm_periods", 32'(bus.PERIODS), 32'd1);
    for (int i = 0; i < 254; i++) run_period(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, h, dl);
    check("periods_ff", 32'(bus.PERIODS), 32'hFF);
    bus.IRQ_ACK = 1'b1;
    tick();
    check("pre_wrap_irq_clear", 32'(bus.IRQ), 32'd0);
    run_to_wrap(h, ok);
    check("periods_wrap_zero", 32'(bus.PERIODS), 32'd0);
    check("periods_wrap_irq", 32'(bus.IRQ), 32'd1);
    for (int i = 0; i < 5; i++) run_period(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, h, dl);
    tick();
    tick();
    check_outs("pre_reset", 1'b1, 8'hFF, 8'h05, 1'b1);

    // Asynchronous reset between clock edges.
    #3;
    rst = 1'b1;
    #1;
    check_outs("async_reset", 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.DUTY = 8'h80;
    bus.DUTY_WE = 1'b1;
    tick();
    run_to_wrap(h, ok);
    check("post_reset_armed_low", 32'(h), 32'd0);
    check("post_reset_da", 32'(bus.DUTY_ACTIVE), 32'h80);
    check("post_reset_periods", 32'(bus.PERIODS), 32'd1);
    tick();
    check("post_reset_pwm", 32'(bus.PWM), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
